// File: rtl/riscv_fetch_ctrl_if.sv
// ============================================================================
// Module      : riscv_fetch_ctrl_if
// Description : Fetch-side bus bundle: instruction-memory request/response,
//               decode hand-off and redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_fetch_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output req_valid, req_addr, if_valid, if_instr, if_pc,
    input  req_ready, rsp_valid, rsp_data, if_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, if_valid, if_instr, if_pc,
    output req_ready, rsp_valid, rsp_data, if_ready, redirect_valid, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/riscv_fetch_ctrl.sv
// ============================================================================
// Module      : riscv_fetch_ctrl
// Description : Single-outstanding instruction fetch controller with a
//               one-entry decode buffer and redirect/drain handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_fetch_ctrl #(
  parameter logic [63:0] RESETVEC = 64'h8000_0000
) (
  input  wire logic          clk,
  input  wire logic          reset,
  riscv_fetch_ctrl_if.master bus
);

  localparam logic [1:0] c_st_fetch = 2'd0;
  localparam logic [1:0] c_st_wait  = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_full  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [63:0] r_pc;
  logic [63:0] r_inflight_pc;
  logic [31:0] r_if_instr;
  logic [63:0] r_if_pc;
  logic        w_req_fire;
  logic        w_capture;
  logic [63:0] w_redirect_pc;

  assign w_req_fire    = (r_state == c_st_fetch) && bus.req_ready;
  assign w_capture     = (r_state == c_st_wait) && bus.rsp_valid && !bus.redirect_valid;
  assign w_redirect_pc = bus.redirect_pc & ~64'h3;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_fetch;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_fetch: begin
        if (w_req_fire) begin
          w_next_state = bus.redirect_valid ? c_st_drain : c_st_wait;
        end
      end
      c_st_wait: begin
        if (bus.redirect_valid) begin
          w_next_state = bus.rsp_valid ? c_st_fetch : c_st_drain;
        end else if (bus.rsp_valid) begin
          w_next_state = c_st_full;
        end
      end
      c_st_drain: begin
        // The stale response retires the outstanding request even if another
        // redirect lands in the same cycle, so nothing is left to drain.
        if (bus.rsp_valid) begin
          w_next_state = c_st_fetch;
        end
      end
      c_st_full: begin
        if (bus.redirect_valid || bus.if_ready) begin
          w_next_state = c_st_fetch;
        end
      end
      default: w_next_state = c_st_fetch;
    endcase
  end

  // Output logic; req_valid is also masked by reset so it is low while held
  always_comb begin
    bus.req_valid = (r_state == c_st_fetch) && !reset;
    bus.req_addr  = r_pc;
    bus.if_valid  = (r_state == c_st_full);
  end

  assign bus.if_instr = r_if_instr;
  assign bus.if_pc    = r_if_pc;

  // Program counter and in-flight address; redirect wins over sequential step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESETVEC;
      r_inflight_pc <= 64'h0;
    end else begin
      if (bus.redirect_valid) begin
        r_pc <= w_redirect_pc;
      end else if (w_req_fire) begin
        r_pc <= r_pc + 64'd4;
      end
      if (w_req_fire) begin
        r_inflight_pc <= r_pc;
      end
    end
  end

  // Decode buffer, loaded only from a response that is not being discarded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_instr <= 32'h0;
      r_if_pc    <= 64'h0;
    end else if (w_capture) begin
      r_if_instr <= bus.rsp_data;
      r_if_pc    <= r_inflight_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_fetch_ctrl.sv
// ============================================================================
// Module      : tb_riscv_fetch_ctrl
// Description : Directed vector table plus randomized memory/decode scoreboard
//               for riscv_fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_fetch_ctrl;

  logic clk;
  logic reset;

  riscv_fetch_ctrl_if bus ();

  riscv_fetch_ctrl #(.RESETVEC(64'h8000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rr;
    bit          rv;
    logic [31:0] rd;
    bit          ir;
    bit          redir;
    logic [63:0] rpc;
    bit          e_req_valid;
    logic [63:0] e_req_addr;
    bit          e_if_valid;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input bit rr, input bit rv, input logic [31:0] rd, input bit ir,
                     input bit redir, input logic [63:0] rpc, input bit erv,
                     input logic [63:0] eaddr, input bit eiv, input logic [31:0] einstr,
                     input logic [63:0] epc);
    vec_t v;
    v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir; v.redir = redir; v.rpc = rpc;
    v.e_req_valid = erv; v.e_req_addr = eaddr; v.e_if_valid = eiv;
    v.e_instr = einstr; v.e_pc = epc;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit rr, input bit rv, input logic [31:0] rd, input bit ir,
                       input bit redir, input logic [63:0] rpc);
    bus.req_ready      = rr;
    bus.rsp_valid      = rv;
    bus.rsp_data       = rd;
    bus.if_ready       = ir;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0013;
  endfunction

  localparam logic [63:0] c_rv   = 64'h8000_0000;
  localparam logic [63:0] c_top  = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    logic [63:0] exp_addr;
    bit          pend_active;
    int          pend_cnt;
    logic [31:0] pend_data;
    int          popped;
    int          cyc;
    bit          rr;
    bit          ir;
    sb_t         e;

    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 64'h0);

    // rr rv data ir redir rpc | req_valid req_addr if_valid instr pc
    for (int i = 0; i < 5; i++)
      add(0, 0, 32'h0,         0, 0, 64'h0,        1, c_rv,           0, 32'h0,   64'h0);
    add(1, 0, 32'h0,           0, 0, 64'h0,        0, 64'h0,          0, 32'h0,   64'h0);
    add(0, 1, 32'h13,          0, 0, 64'h0,        0, 64'h0,          1, 32'h13,  c_rv);
    add(0, 0, 32'h0,           1, 0, 64'h0,        1, c_rv + 4,       0, 32'h0,   64'h0);
    add(1, 0, 32'h0,           0, 0, 64'h0,        0, 64'h0,          0, 32'h0,   64'h0);
    add(0, 1, 32'h13,          0, 0, 64'h0,        0, 64'h0,          1, 32'h13,  c_rv + 4);
    add(0, 0, 32'h0,           0, 0, 64'h0,        0, 64'h0,          1, 32'h13,  c_rv + 4);
    add(1, 0, 32'h0,           0, 0, 64'h0,        0, 64'h0,          1, 32'h13,  c_rv + 4);
    add(0, 1, 32'hDEAD_BEEF,   0, 0, 64'h0,        0, 64'h0,          1, 32'h13,  c_rv + 4);
    add(0, 0, 32'h0,           0, 0, 64'h0,        0, 64'h0,          1, 32'h13,  c_rv + 4);
    add(0, 0, 32'h0,           1, 0, 64'h0,        1, c_rv + 8,       0, 32'h0,   64'h0);
    // redirect during WAIT, stale response two cycles later
    add(1, 0, 32'h0,           0, 0, 64'h0,        0, 64'h0,          0, 32'h0,   64'h0);
    add(0, 0, 32'h0,           0, 1, 64'h8000_0102, 0, 64'h0,         0, 32'h0,   64'h0);
    add(0, 0, 32'h0,           0, 0, 64'h0,        0, 64'h0,          0, 32'h0,   64'h0);
    add(0, 1, 32'hBAD0_0001,   0, 0, 64'h0,        1, 64'h8000_0100,  0, 32'h0,   64'h0);
    add(1, 0, 32'h0,           0, 0, 64'h0,        0, 64'h0,          0, 32'h0,   64'h0);
    add(0, 1, 32'h93,          0, 0, 64'h0,        0, 64'h0,          1, 32'h93,  64'h8000_0100);
    // redirect in FULL drops the buffer
    add(0, 0, 32'h0,           0, 1, 64'h8000_0200, 1, 64'h8000_0200, 0, 32'h0,  64'h0);
    // redirect in FETCH without handshake
    add(0, 0, 32'h0,           0, 1, 64'h8000_0301, 1, 64'h8000_0300, 0, 32'h0,  64'h0);
    // redirect coinciding with handshake -> DRAIN
    add(1, 0, 32'h0,           0, 1, 64'h8000_0400, 0, 64'h0,         0, 32'h0,   64'h0);
    add(0, 1, 32'hBAD0_0002,   0, 0, 64'h0,        1, 64'h8000_0400,  0, 32'h0,   64'h0);
    // redirect in WAIT together with rsp -> FETCH
    add(1, 0, 32'h0,           0, 0, 64'h0,        0, 64'h0,          0, 32'h0,   64'h0);
    add(0, 1, 32'hBAD0_0003,   0, 1, 64'h8000_0500, 1, 64'h8000_0500, 0, 32'h0,  64'h0);
    // repeated redirect in DRAIN
    add(1, 0, 32'h0,           0, 0, 64'h0,        0, 64'h0,          0, 32'h0,   64'h0);
    add(0, 0, 32'h0,           0, 1, 64'h8000_0600, 0, 64'h0,         0, 32'h0,   64'h0);
    add(0, 0, 32'h0,           0, 1, 64'h8000_0700, 0, 64'h0,         0, 32'h0,   64'h0);
    add(0, 1, 32'hBAD0_0004,   0, 0, 64'h0,        1, 64'h8000_0700,  0, 32'h0,   64'h0);
    // pc wrap at top of address space
    add(0, 0, 32'h0,           0, 1, c_top,        1, c_top,          0, 32'h0,   64'h0);
    add(1, 0, 32'h0,           0, 0, 64'h0,        0, 64'h0,          0, 32'h0,   64'h0);
    add(0, 1, 32'h113,         0, 0, 64'h0,        0, 64'h0,          1, 32'h113, c_top);
    add(0, 0, 32'h0,           1, 0, 64'h0,        1, 64'h0,          0, 32'h0,   64'h0);
    // response in FETCH is ignored
    add(0, 1, 32'hBAD0_0005,   0, 0, 64'h0,        1, 64'h0,          0, 32'h0,   64'h0);

    // Reset values
    tick();
    tick();
    chk("rst_req_valid", {63'h0, bus.req_valid}, 64'h0);
    chk("rst_if_valid",  {63'h0, bus.if_valid},  64'h0);
    chk("rst_if_instr",  {32'h0, bus.if_instr},  64'h0);
    chk("rst_if_pc",     bus.if_pc,              64'h0);
    reset = 1'b0;
    #1;
    chk("rel_req_valid", {63'h0, bus.req_valid}, 64'h1);
    chk("rel_req_addr",  bus.req_addr,           c_rv);

    foreach (vecs[i]) begin
      drive(vecs[i].rr, vecs[i].rv, vecs[i].rd, vecs[i].ir, vecs[i].redir, vecs[i].rpc);
      tick();
      chk($sformatf("v%0d_req_valid", i), {63'h0, bus.req_valid}, {63'h0, vecs[i].e_req_valid});
      if (vecs[i].e_req_valid)
        chk($sformatf("v%0d_req_addr", i), bus.req_addr, vecs[i].e_req_addr);
      chk($sformatf("v%0d_if_valid", i), {63'h0, bus.if_valid}, {63'h0, vecs[i].e_if_valid});
      if (vecs[i].e_if_valid) begin
        chk($sformatf("v%0d_if_instr", i), {32'h0, bus.if_instr}, {32'h0, vecs[i].e_instr});
        chk($sformatf("v%0d_if_pc", i), bus.if_pc, vecs[i].e_pc);
      end
    end

    // Reset asserted while waiting for a response
    drive(1, 0, 32'h0, 0, 0, 64'h0);
    tick();
    chk("midrst_pre_wait", {63'h0, bus.req_valid}, 64'h0);
    drive(0, 0, 32'h0, 0, 0, 64'h0);
    reset = 1'b1;
    #1;
    chk("midrst_req_valid", {63'h0, bus.req_valid}, 64'h0);
    chk("midrst_if_valid",  {63'h0, bus.if_valid},  64'h0);
    chk("midrst_if_instr",  {32'h0, bus.if_instr},  64'h0);
    chk("midrst_if_pc",     bus.if_pc,              64'h0);
    drive(0, 1, 32'hBAD0_0006, 0, 0, 64'h0);
    tick();
    chk("midrst_rsp_if_valid", {63'h0, bus.if_valid}, 64'h0);
    reset = 1'b0;
    #1;
    chk("midrst_rel_req_valid", {63'h0, bus.req_valid}, 64'h1);
    chk("midrst_rel_req_addr",  bus.req_addr,           c_rv);
    drive(0, 1, 32'hBAD0_0007, 0, 0, 64'h0);
    tick();
    chk("midrst_late_rsp_addr",     bus.req_addr,           c_rv);
    chk("midrst_late_rsp_if_valid", {63'h0, bus.if_valid},  64'h0);

    // Randomized memory latency and decode back-pressure, scoreboarded
    exp_addr    = c_rv;
    pend_active = 0;
    pend_cnt    = 0;
    pend_data   = 32'h0;
    popped      = 0;
    cyc         = 0;
    while (popped < 24 && cyc < 3000) begin
      rr = ($urandom_range(0, 1) == 1);
      ir = ($urandom_range(0, 3) != 0);
      drive(rr, 0, 32'h0, ir, 0, 64'h0);
      if (pend_active) begin
        if (pend_cnt == 1) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_data  = pend_data;
          pend_active   = 0;
        end else begin
          pend_cnt--;
        end
      end
      if (bus.req_valid) begin
        chk("sb_req_addr", bus.req_addr, exp_addr);
        if (rr) begin
          e.pc    = exp_addr;
          e.instr = mem_word(exp_addr);
          sbq.push_back(e);
          pend_active = 1;
          pend_cnt    = $urandom_range(1, 3);
          pend_data   = e.instr;
          exp_addr    = exp_addr + 64'd4;
        end
      end
      if (bus.if_valid && ir) begin
        chk("sb_queue_nonempty", {63'h0, sbq.size() != 0}, 64'h1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("sb_if_pc",    bus.if_pc,              e.pc);
          chk("sb_if_instr", {32'h0, bus.if_instr},  {32'h0, e.instr});
          popped++;
        end
      end
      tick();
      cyc++;
    end
    chk("sb_instr_count", 64'(popped), 64'd24);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_fetch_ctrl.md
RISCV_FETCH_CTRL -- requirements
Module: riscv_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESETVEC, default 64'h8000_0000: PC loaded on reset.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  output  1: instruction-memory fetch request.
REQ-005 SHALL have port req_ready  input  1: memory accepts the request.
REQ-006 SHALL have port req_addr  output  64: fetch address.
REQ-007 SHALL have port rsp_valid  input  1: memory returns data, one cycle pulse per accepted request.
REQ-008 SHALL have port rsp_data  input  32: returned instruction word.
REQ-009 SHALL have port if_valid  output  1: fetched instruction available to decode.
REQ-010 SHALL have port if_ready  input  1: decode accepts the instruction.
REQ-011 SHALL have port if_instr  output  32: buffered instruction.
REQ-012 SHALL have port if_pc  output  64: address of if_instr.
REQ-013 SHALL have port redirect_valid  input  1: branch/jump/trap redirect.
REQ-014 SHALL have port redirect_pc  input  64: redirect target.

Function
REQ-015 SHALL implement states FETCH, WAIT, DRAIN and FULL, with at most one memory request outstanding.
REQ-016 SHALL drive req_valid=1 and req_addr=pc only in FETCH; req_valid=0 in every other state.
REQ-017 SHALL drive if_valid=1 only in FULL; if_instr and if_pc hold the captured values while if_valid=1.
REQ-018 SHALL treat a request handshake as req_valid&req_ready; on it, latch pc into inflight_pc, set pc<=pc+4 (modulo 2^64, wraps silently), and go to WAIT.
REQ-019 SHALL, in WAIT on rsp_valid, capture rsp_data into if_instr and inflight_pc into if_pc, then go to FULL.
REQ-020 SHALL, in FULL on if_valid&if_ready, go to FETCH; next request issues the following cycle.
REQ-021 SHALL have minimum latency of 2 cycles: handshake in cycle N, rsp_valid in cycle N+1, if_valid in cycle N+2.
REQ-022 SHALL, on redirect_valid in any state, load pc<=redirect_pc with bits [1:0] forced to 0; redirect overrides the pc+4 update.
REQ-023 SHALL, on redirect in FETCH without a handshake, stay in FETCH; req_addr may change while req_valid=1 only in this case.
REQ-024 SHALL, on redirect in FETCH coinciding with a handshake, go to DRAIN; the old-address request is in flight and its response is discarded.
REQ-025 SHALL, on redirect in WAIT, go to FETCH if rsp_valid is also high that cycle (response discarded); otherwise go to DRAIN.
REQ-026 SHALL, in DRAIN, discard the response on rsp_valid and go to FETCH; a further redirect in DRAIN updates pc and stays in DRAIN.
REQ-027 SHALL, on redirect in FULL, drop the buffered instruction and go to FETCH; if if_ready is high the same cycle, decode has consumed it.
REQ-028 SHALL ignore rsp_valid in FETCH and FULL, with no state or output change.
REQ-029 SHALL never present a discarded (stale) response on if_instr with if_valid=1.

Reset
REQ-030 SHALL, while reset=1, force state=FETCH, pc=RESETVEC, req_valid=0, if_valid=0, if_instr=0, if_pc=0, inflight_pc=0.
REQ-031 SHALL, in the first cycle after reset deasserts, drive req_valid=1 and req_addr=RESETVEC.
REQ-032 SHALL, on reset asserted mid-transaction (WAIT/DRAIN/FULL), abandon it immediately; any later rsp_valid arrives in FETCH and is ignored per REQ-028.

Verification
REQ-033 SHALL be checked with: reset release, req_ready=1, rsp one cycle later with 32'h00000013, if_ready=1 -> if_pc=64'h8000_0000 then 64'h8000_0004, each with if_instr=32'h00000013.
REQ-034 SHALL be checked with: req_ready=0 for 5 cycles -> req_valid=1 held, req_addr stable at 64'h8000_0000, pc not advanced.
REQ-035 SHALL be checked with: redirect to 64'h8000_0102 during WAIT, stale rsp 2 cycles later -> stale word never on if_instr; next req_addr=64'h8000_0100.
REQ-036 SHALL be checked with: if_ready=0 for 4 cycles in FULL -> if_valid, if_instr and if_pc stable, and no new request.
REQ-037 SHALL be checked with: pc=64'hFFFF_FFFF_FFFF_FFFC accepted -> next req_addr=64'h0.
REQ-038 SHALL be checked with: reset asserted in WAIT, then rsp_valid pulse -> outputs at reset values; first request after release at RESETVEC.
